// File: rtl/dual_port_ram_pkg.sv
// Shared types and default sizing for the dual-port byte-enable RAM.
package dual_port_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/dpr_write_arbiter.sv
// Resolves the byte lanes each port may write this cycle and flags
// same-address write/write collisions on overlapping lanes.
module dpr_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int BE_W   = 8
) (
  input  logic              a_wr,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_wr,
  input  logic [BE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [BE_W-1:0]   a_lanes,
  output logic [BE_W-1:0]   b_lanes,
  output logic              coll
);

  logic            same_addr;
  logic [BE_W-1:0] overlap;

  always_comb begin
    same_addr = (a_addr == b_addr);
    overlap   = a_be & b_be;
    a_lanes   = a_wr ? a_be : '0;
    b_lanes   = '0;
    // Port A owns any lane both ports target on the same word.
    if (b_wr) b_lanes = (a_wr && same_addr) ? (b_be & ~a_be) : b_be;
    coll = a_wr && b_wr && same_addr && (overlap != '0);
  end

endmodule

// File: rtl/dual_port_ram_param.sv
// Dual-port RAM with byte enables, read-first registered reads, a zeroing
// sweep after reset, and write/write collision reporting.
module dual_port_ram_param
  import dual_port_ram_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_rvalid,
  output logic              init_done,
  output logic              coll_pulse,
  output logic [CNT_W-1:0]  coll_cnt,
  output state_t            fsm_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              run;
  logic              a_wr, b_wr, a_rd, b_rd;
  logic [BE_W-1:0]   a_lanes, b_lanes;
  logic              coll;

  assign run       = (state == RUN);
  assign a_wr      = run && a_en && a_we;
  assign b_wr      = run && b_en && b_we;
  assign a_rd      = run && a_en && !a_we;
  assign b_rd      = run && b_en && !b_we;
  assign fsm_state = state;

  dpr_write_arbiter #(
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_arb (
    .a_wr    (a_wr),
    .a_be    (a_be),
    .a_addr  (a_addr),
    .b_wr    (b_wr),
    .b_be    (b_be),
    .b_addr  (b_addr),
    .a_lanes (a_lanes),
    .b_lanes (b_lanes),
    .coll    (coll)
  );

  // Storage has no reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run) begin
        mem[clr_ptr] <= '0;
      end else begin
        for (int i = 0; i < BE_W; i++) begin
          if (a_lanes[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
          if (b_lanes[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Nonblocking reads sample the array before this edge's writes land.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_dout   <= '0;
      b_dout   <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_dout <= mem[a_addr];
      if (b_rd) b_dout <= mem[b_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_pulse <= 1'b0;
      coll_cnt   <= '0;
    end else begin
      coll_pulse <= coll;
      if (coll && (coll_cnt != {CNT_W{1'b1}})) coll_cnt <= coll_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Randomized and directed checks of dual_port_ram_param against a
// behavioural memory model.
module tb_dual_port_ram_param;
  import dual_port_ram_pkg::*;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int CW = 4;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
  logic [7:0]    a_be = '0, b_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic [DW-1:0] a_dout, b_dout;
  logic          a_rvalid, b_rvalid, init_done, coll_pulse;
  logic [CW-1:0] coll_cnt;
  state_t        fsm_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_a_dout, ref_b_dout;
  logic          ref_a_rv, ref_b_rv, ref_cp;
  int            ref_cnt;
  bit            ref_run;
  int            ref_init_left;

  dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
    .b_dout(b_dout), .b_rvalid(b_rvalid),
    .init_done(init_done), .coll_pulse(coll_pulse), .coll_cnt(coll_cnt),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic set_a(input logic en, input logic we, input logic [7:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    a_en = en; a_we = we; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic set_b(input logic en, input logic we, input logic [7:0] be,
                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    b_en = en; b_we = we; b_be = be; b_addr = addr; b_din = din;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 8'h00, '0, '0);
    set_b(1'b0, 1'b0, 8'h00, '0, '0);
  endtask

  // Reference model: applies the current inputs, then advances one clock.
  task automatic step();
    bit a_w, b_w, a_r, b_r;
    if (!rst_n) begin
      ref_a_dout = '0; ref_b_dout = '0; ref_a_rv = 0; ref_b_rv = 0; ref_cp = 0;
      ref_cnt = 0; ref_run = 0; ref_init_left = DEPTH;
      for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    end else if (!ref_run) begin
      ref_a_rv = 0; ref_b_rv = 0; ref_cp = 0;
      ref_init_left--;
      if (ref_init_left == 0) ref_run = 1;
    end else begin
      a_w = a_en && a_we; b_w = b_en && b_we;
      a_r = a_en && !a_we; b_r = b_en && !b_we;
      ref_a_rv = a_r; ref_b_rv = b_r;
      if (a_r) ref_a_dout = ref_mem[a_addr];
      if (b_r) ref_b_dout = ref_mem[b_addr];
      ref_cp = a_w && b_w && (a_addr == b_addr) && ((a_be & b_be) != 8'h00);
      if (ref_cp && ref_cnt < (2**CW - 1)) ref_cnt++;
      if (b_w) for (int i = 0; i < 8; i++) if (b_be[i]) ref_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
      if (a_w) for (int i = 0; i < 8; i++) if (a_be[i]) ref_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++; if (a_dout !== '0 || b_dout !== '0) begin n_fail++; $display("FAIL %s_dout: got a=%h b=%h want 0", tag, a_dout, b_dout); end
    n_tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_fail++; $display("FAIL %s_rvalid: got a=%b b=%b want 0", tag, a_rvalid, b_rvalid); end
    n_tests++; if (coll_pulse !== 1'b0 || coll_cnt !== '0) begin n_fail++; $display("FAIL %s_coll: got pulse=%b cnt=%0d want 0", tag, coll_pulse, coll_cnt); end
    n_tests++; if (init_done !== 1'b0 || fsm_state !== INIT) begin n_fail++; $display("FAIL %s_state: got init_done=%b state=%0d want 0/INIT", tag, init_done, fsm_state); end
  endtask

  // Steps through INIT with random (ignored) requests and counts the cycles.
  task automatic wait_init(input string tag);
    int n = 0;
    bit bad = 0;
    while (init_done !== 1'b1 && n < 200) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'hFF, AW'($urandom_range(0, 63)), {$urandom, $urandom});
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'hFF, AW'($urandom_range(0, 63)), {$urandom, $urandom});
      step();
      n++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || coll_pulse !== 1'b0) bad = 1;
    end
    idle();
    n_tests++; if (n != DEPTH) begin n_fail++; $display("FAIL %s_init_cycles: got %0d want %0d", tag, n, DEPTH); end
    n_tests++; if (init_done !== 1'(ref_run)) begin n_fail++; $display("FAIL %s_init_done: got %b want %b", tag, init_done, ref_run); end
    n_tests++; if (bad) begin n_fail++; $display("FAIL %s_init_quiet: rvalid/coll_pulse seen during INIT, want none", tag); end
  endtask

  task automatic test_readback(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      set_a(1'b1, 1'b0, 8'h00, AW'(k), '0);
      set_b(1'b1, 1'b0, 8'h00, AW'(DEPTH - 1 - k), '0);
      step();
      n_tests++; if (a_dout !== ref_a_dout || a_rvalid !== 1'b1) begin n_fail++; $display("FAIL %s_a[%0d]: got %h rv=%b want %h rv=1", tag, k, a_dout, a_rvalid, ref_a_dout); end
      n_tests++; if (b_dout !== ref_b_dout || b_rvalid !== 1'b1) begin n_fail++; $display("FAIL %s_b[%0d]: got %h rv=%b want %h rv=1", tag, DEPTH - 1 - k, b_dout, b_rvalid, ref_b_dout); end
    end
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    step(); step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_init("reset");
  endtask

  task automatic test_init_zero();
    int addrs[3] = '{0, 31, 63};
    foreach (addrs[k]) begin
      set_a(1'b1, 1'b0, 8'h00, AW'(addrs[k]), '0);
      step();
      n_tests++; if (a_rvalid !== 1'b1 || a_dout !== 64'h0) begin n_fail++; $display("FAIL init_zero[%0d]: got %h rv=%b want 0 rv=1", addrs[k], a_dout, a_rvalid); end
    end
    set_a(1'b1, 1'b1, 8'hFF, 6'd1, 64'h1234_5678_9ABC_DEF0); step();
    set_a(1'b1, 1'b0, 8'h00, 6'd1, '0); step();
    idle(); step(); step();
    n_tests++; if (a_rvalid !== 1'b0 || a_dout !== 64'h1234_5678_9ABC_DEF0) begin n_fail++; $display("FAIL dout_hold: got %h rv=%b want 123456789abcdef0 rv=0", a_dout, a_rvalid); end
  endtask

  task automatic test_byte_write();
    set_a(1'b1, 1'b1, 8'h0F, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF); step();
    n_tests++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got %b want 0", a_rvalid); end
    set_a(1'b1, 1'b0, 8'h00, 6'd5, '0); step();
    n_tests++; if (a_dout !== 64'h0000_0000_FFFF_FFFF || a_rvalid !== 1'b1) begin n_fail++; $display("FAIL byte_write: got %h rv=%b want 00000000ffffffff rv=1", a_dout, a_rvalid); end
    set_a(1'b1, 1'b1, 8'h00, 6'd5, 64'h0); step();
    set_a(1'b1, 1'b0, 8'h00, 6'd5, '0); step();
    n_tests++; if (a_dout !== 64'h0000_0000_FFFF_FFFF || coll_cnt !== '0) begin n_fail++; $display("FAIL be_zero: got %h cnt=%0d want 00000000ffffffff cnt=0", a_dout, coll_cnt); end
    idle(); step();
  endtask

  task automatic test_collision();
    set_a(1'b1, 1'b1, 8'hFF, 6'd9, {8{8'h11}});
    set_b(1'b1, 1'b1, 8'hF0, 6'd9, {8{8'h22}});
    step();
    n_tests++; if (coll_pulse !== 1'b1 || coll_cnt !== 4'd1) begin n_fail++; $display("FAIL coll_first: got pulse=%b cnt=%0d want 1/1", coll_pulse, coll_cnt); end
    idle();
    set_b(1'b1, 1'b0, 8'h00, 6'd9, '0); step();
    n_tests++; if (coll_pulse !== 1'b0 || coll_cnt !== 4'd1) begin n_fail++; $display("FAIL coll_once: got pulse=%b cnt=%0d want 0/1", coll_pulse, coll_cnt); end
    n_tests++; if (b_dout !== {8{8'h11}}) begin n_fail++; $display("FAIL coll_data: got %h want 1111111111111111", b_dout); end
    idle(); step();
  endtask

  task automatic test_merge();
    set_a(1'b1, 1'b1, 8'h0F, 6'd3, {8{8'hAA}});
    set_b(1'b1, 1'b1, 8'hF0, 6'd3, {8{8'hBB}});
    step();
    idle();
    set_a(1'b1, 1'b0, 8'h00, 6'd3, '0); step();
    n_tests++; if (a_dout !== 64'hBBBB_BBBB_AAAA_AAAA) begin n_fail++; $display("FAIL merge_data: got %h want bbbbbbbbaaaaaaaa", a_dout); end
    n_tests++; if (coll_cnt !== 4'd1 || coll_pulse !== 1'b0) begin n_fail++; $display("FAIL merge_no_coll: got pulse=%b cnt=%0d want 0/1", coll_pulse, coll_cnt); end
    idle(); step();
  endtask

  task automatic test_read_first();
    set_a(1'b1, 1'b1, 8'hFF, 6'd7, 64'h5); step();
    set_a(1'b1, 1'b1, 8'hFF, 6'd7, 64'h9);
    set_b(1'b1, 1'b0, 8'h00, 6'd7, '0);
    step();
    n_tests++; if (b_dout !== 64'h5 || b_rvalid !== 1'b1) begin n_fail++; $display("FAIL read_first: got %h rv=%b want 5 rv=1", b_dout, b_rvalid); end
    set_a(1'b0, 1'b0, 8'h00, '0, '0); step();
    n_tests++; if (b_dout !== 64'h9) begin n_fail++; $display("FAIL read_after_write: got %h want 9", b_dout); end
    idle(); step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), AW'($urandom_range(0, 7)), {$urandom, $urandom});
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), AW'($urandom_range(0, 7)), {$urandom, $urandom});
      step();
      n_tests++; if (a_rvalid !== ref_a_rv || a_dout !== ref_a_dout) begin n_fail++; $display("FAIL rand_a c=%0d: got %h rv=%b want %h rv=%b", c, a_dout, a_rvalid, ref_a_dout, ref_a_rv); end
      n_tests++; if (b_rvalid !== ref_b_rv || b_dout !== ref_b_dout) begin n_fail++; $display("FAIL rand_b c=%0d: got %h rv=%b want %h rv=%b", c, b_dout, b_rvalid, ref_b_dout, ref_b_rv); end
      n_tests++; if (coll_pulse !== ref_cp || coll_cnt !== CW'(ref_cnt)) begin n_fail++; $display("FAIL rand_coll c=%0d: got pulse=%b cnt=%0d want %b/%0d", c, coll_pulse, coll_cnt, ref_cp, ref_cnt); end
    end
    idle(); step();
    test_readback("rand_mem");
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      set_a(1'b1, 1'b1, 8'hFF, AW'($urandom_range(0, 63)), {$urandom, $urandom});
      set_b(1'b1, 1'b1, 8'($urandom_range(1, 255)), a_addr, {$urandom, $urandom});
      step();
      n_tests++; if (coll_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse c=%0d: got %b want 1", c, coll_pulse); end
    end
    idle(); step();
    n_tests++; if (coll_cnt !== 4'd15 || coll_cnt !== CW'(ref_cnt)) begin n_fail++; $display("FAIL sat_cnt: got %0d want 15", coll_cnt); end
  endtask

  task automatic test_reset_mid_init();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0; step();
    check_reset_outputs("mid_init");
    rst_n = 1'b1;
    wait_init("mid_init");
    test_readback("mid_init_mem");
  endtask

  task automatic test_reset_pending_read();
    set_a(1'b1, 1'b1, 8'hFF, 6'd10, 64'hDEAD_BEEF_CAFE_F00D); step();
    set_a(1'b1, 1'b0, 8'h00, 6'd10, '0);
    set_b(1'b1, 1'b0, 8'h00, 6'd10, '0);
    rst_n = 1'b0; step();
    check_reset_outputs("pend_read");
    rst_n = 1'b1;
    wait_init("pend_read");
    step();
    n_tests++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin n_fail++; $display("FAIL stale_rvalid: got a=%b b=%b want 0", a_rvalid, b_rvalid); end
    set_a(1'b1, 1'b0, 8'h00, 6'd10, '0); step();
    n_tests++; if (a_dout !== 64'h0) begin n_fail++; $display("FAIL pend_read_swept: got %h want 0", a_dout); end
    idle(); step();
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_byte_write();
    test_collision();
    test_merge();
    test_read_first();
    test_random();
    test_saturation();
    test_reset_mid_init();
    test_reset_pending_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
